// File: rtl/timer_irq_source_pkg.sv
// timer_irq_source_pkg
//   Shared constants for the memory-mapped countdown timer: bus word indices,
//   CTRL bit positions, mode encodings and the FSM state type.
package timer_irq_source_pkg;

    // Word indices on bus address [3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions: {IM, MODE[1:0], EN}
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // MODE encodings; 2 and 3 behave as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_irq_source_prescaler.sv
// timer_prescaler
//   Free-running modulo-PRESCALE_DIV counter. tick is high during the last
//   cycle of each period; clear restarts the period from zero.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   clear  synchronous restart of the modulo count
//   tick   high when the count equals PRESCALE_DIV-1
module timer_prescaler #(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = $clog2(PRESCALE_DIV);
    localparam logic [W-1:0] LAST = W'(PRESCALE_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/timer_irq_source.sv
// timer_irq_source
//   Memory-mapped countdown timer feeding one CP0 HWInt bit. Supports
//   one-shot (MODE 0, also 2/3) and auto-reload (MODE 1) operation.
//   Define TIMER_PRESCALE_EN to step COUNT once every PRESCALE_DIV cycles.
// Ports:
//   clk    system clock, all state on rising edge
//   reset  synchronous active-low reset
//   addr   word select (bus addr[3:2]): 0=CTRL 1=PRESET 2=COUNT 3=unused
//   we     write strobe from MEM-stage store decode
//   wdata  store data
//   rdata  combinational read data of the selected word
//   irq    interrupt request = irq_flag & IM
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;
    state_t      state_next;

    logic en;
    logic im;
    logic reload;
    logic wr_ctrl;
    logic wr_preset;
    logic count_tick;

    // Decoded actions for the datapath
    logic load_count;
    logic dec_count;
    logic expire;
    logic int_oneshot;
    logic int_reload;

    assign en        = ctrl[CTRL_EN];
    assign im        = ctrl[CTRL_IM];
    assign reload    = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign wr_ctrl   = we && (addr == TC_CTRL);
    assign wr_preset = we && (addr == TC_PRESET);

    if (PRESCALE_DIV < 2) begin : g_div_check
        $error("PRESCALE_DIV must be at least 2");
    end

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(load_count),
        .tick (count_tick)
    );
`else
    assign count_tick = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (en) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_CNT;
            ST_CNT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (count_tick && (count <= 32'd1)) begin
                    state_next = ST_INT;
                end
            end
            ST_INT: state_next = reload ? ST_LOAD : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        load_count  = 1'b0;
        dec_count   = 1'b0;
        expire      = 1'b0;
        int_oneshot = 1'b0;
        int_reload  = 1'b0;
        irq         = irq_flag & im;
        unique case (state)
            ST_LOAD: load_count = 1'b1;
            ST_CNT: begin
                if (en && count_tick) begin
                    if (count > 32'd1) dec_count = 1'b1;
                    else               expire    = 1'b1;
                end
            end
            ST_INT: begin
                if (reload) int_reload  = 1'b1;
                else        int_oneshot = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file and counter. Software writes take priority over the
    // FSM's own EN clear and irq_flag updates at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata[3:0];
            end else if (int_oneshot) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_preset) begin
                preset <= wdata;
            end

            if (load_count) begin
                count <= preset;
            end else if (dec_count) begin
                count <= count - 32'd1;
            end else if (expire) begin
                count <= '0;
            end

            if (wr_ctrl || wr_preset) begin
                irq_flag <= 1'b0;
            end else if (expire) begin
                irq_flag <= 1'b1;
            end else if (int_reload) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        unique case (addr)
            TC_CTRL:   rdata = {28'b0, ctrl};
            TC_PRESET: rdata = preset;
            TC_COUNT:  rdata = count;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source
//   Self-checking bench for timer_irq_source. Expected values come from a
//   closed-form timeline model: after the EN write edge (t=0), LOAD executes
//   at t=2, then each reload period lasts max(N,1)*S+2 cycles.
module tb_timer_irq_source;

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned S = 4;
`else
    localparam int unsigned S = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    timer_irq_source #(
        .PRESCALE_DIV(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // Expected COUNT / irq / CTRL at t cycles after the enabling CTRL write,
    // starting from a freshly reset timer.
    function automatic void model(input int unsigned t, input int unsigned n,
                                  input logic [3:0] c, output logic [31:0] cnt,
                                  output logic irq_e, output logic [3:0] ctrl_e);
        int unsigned run, per, j, k;
        run    = ((n == 0) ? 1 : n) * S;
        per    = run + 2;
        cnt    = '0;
        irq_e  = 1'b0;
        ctrl_e = c;
        if (t < 2) return;
        j = t - 2;
        if (c[2:1] != 2'd1 && j >= run) begin
            irq_e = c[3];
            if (j >= run + 1) ctrl_e[0] = 1'b0;
        end else begin
            k = (c[2:1] == 2'd1) ? (j % per) : j;
            if (k < run)       cnt = 32'(n - k / S);
            else if (k == run) irq_e = c[3];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h9);
        repeat (3) step();
        do_reset();
        for (int unsigned a = 0; a < 3; a++) begin
            rd(2'(a), d);
            n_cmp++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL reset_rdata addr=%0d got %h exp 0", a, d); end
        end
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] c, k, ec;
        logic ei;
        logic [3:0] ek;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int unsigned t = 1; t <= 2 + 5 * S + 4; t++) begin
            step();
            model(t, 5, 4'h9, ec, ei, ek);
            rd(2'd2, c); rd(2'd0, k);
            n_cmp++;
            if (c !== ec) begin n_fail++; $display("FAIL oneshot_count t=%0d got %0d exp %0d", t, c, ec); end
            n_cmp++;
            if (irq !== ei) begin n_fail++; $display("FAIL oneshot_irq t=%0d got %b exp %b", t, irq, ei); end
            n_cmp++;
            if (k !== {28'b0, ek}) begin n_fail++; $display("FAIL oneshot_ctrl t=%0d got %h exp %h", t, k, ek); end
        end
        wr(2'd0, 32'h8);
        rd(2'd0, k);
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear_irq got %b exp 0", irq); end
        n_cmp++;
        if (k !== 32'h8) begin n_fail++; $display("FAIL oneshot_clear_ctrl got %h exp 8", k); end
    endtask

    task automatic test_reload();
        logic [31:0] c, ec;
        logic ei;
        logic [3:0] ek;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int unsigned t = 1; t <= 2 + 3 * (3 * S + 2); t++) begin
            step();
            model(t, 3, 4'hB, ec, ei, ek);
            rd(2'd2, c);
            n_cmp++;
            if (c !== ec) begin n_fail++; $display("FAIL reload_count t=%0d got %0d exp %0d", t, c, ec); end
            n_cmp++;
            if (irq !== ei) begin n_fail++; $display("FAIL reload_irq t=%0d got %b exp %b", t, irq, ei); end
        end
    endtask

    task automatic test_masked();
        logic [31:0] c, ec;
        logic ei;
        logic [3:0] ek;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h3);
        for (int unsigned t = 1; t <= 2 + 3 * (2 * S + 2); t++) begin
            step();
            model(t, 2, 4'h3, ec, ei, ek);
            rd(2'd2, c);
            n_cmp++;
            if (c !== ec) begin n_fail++; $display("FAIL masked_count t=%0d got %0d exp %0d", t, c, ec); end
            n_cmp++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq t=%0d got %b exp 0", t, irq); end
        end
    endtask

    task automatic test_stop_ignored();
        logic [31:0] c, k, frozen;
        logic ei;
        logic [3:0] ek;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (3) step();
        wr(2'd0, 32'h0);
        model(4, 10, 4'h9, frozen, ei, ek);
        wr(2'd2, 32'h55);
        for (int unsigned t = 0; t < 5; t++) begin
            rd(2'd2, c); rd(2'd0, k);
            n_cmp++;
            if (c !== frozen) begin n_fail++; $display("FAIL stop_count t=%0d got %0d exp %0d", t, c, frozen); end
            n_cmp++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL stop_irq t=%0d got %b exp 0", t, irq); end
            n_cmp++;
            if (k !== 32'h0) begin n_fail++; $display("FAIL stop_ctrl t=%0d got %h exp 0", t, k); end
            step();
        end
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] c, ec;
        logic ei;
        logic [3:0] ek;
        int unsigned p1, p2;
        p1 = 4 * S + 2;
        p2 = 2 * S + 2;
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        for (int unsigned t = 1; t <= 2 + p1 + 2 * p2; t++) begin
            if (t == 3) begin addr = 2'd1; wdata = 32'd2; we = 1'b1; end
            step();
            we = 1'b0;
            if (t < 2 + p1) model(t, 4, 4'hB, ec, ei, ek);
            else            model(t - p1, 2, 4'hB, ec, ei, ek);
            rd(2'd2, c);
            n_cmp++;
            if (c !== ec) begin n_fail++; $display("FAIL presetcnt_count t=%0d got %0d exp %0d", t, c, ec); end
            n_cmp++;
            if (irq !== ei) begin n_fail++; $display("FAIL presetcnt_irq t=%0d got %b exp %b", t, irq, ei); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int unsigned rise;
        rise = 0;
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        for (int unsigned t = 1; t <= 40 && rise == 0; t++) begin
            step();
            if (irq === 1'b1) rise = t;
        end
        n_cmp++;
        if (rise != 2 + S) begin n_fail++; $display("FAIL resetmid_rise got t=%0d exp t=%0d", rise, 2 + S); end
        do_reset();
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL resetmid_irq got %b exp 0", irq); end
        for (int unsigned a = 0; a < 3; a++) begin
            rd(2'(a), d);
            n_cmp++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL resetmid_rdata addr=%0d got %h exp 0", a, d); end
        end
        step();
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL resetmid_irq_hold got %b exp 0", irq); end
    endtask

    task automatic test_random();
        logic [31:0] c, k, ec;
        logic ei;
        logic [3:0] ek, cv;
        int unsigned n, per;
        for (int unsigned it = 0; it < 24; it++) begin
            n  = $urandom_range(0, 6);
            cv = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            per = ((n == 0) ? 1 : n) * S + 2;
            do_reset();
            wr(2'd1, 32'(n));
            wr(2'd0, 32'(cv));
            for (int unsigned t = 1; t <= 2 * per + 3; t++) begin
                step();
                model(t, n, cv, ec, ei, ek);
                rd(2'd2, c); rd(2'd0, k);
                n_cmp++;
                if (c !== ec) begin n_fail++; $display("FAIL rand_count it=%0d n=%0d ctrl=%h t=%0d got %0d exp %0d", it, n, cv, t, c, ec); end
                n_cmp++;
                if (irq !== ei) begin n_fail++; $display("FAIL rand_irq it=%0d n=%0d ctrl=%h t=%0d got %b exp %b", it, n, cv, t, irq, ei); end
                n_cmp++;
                if (k !== {28'b0, ek}) begin n_fail++; $display("FAIL rand_ctrl it=%0d n=%0d ctrl=%h t=%0d got %h exp %h", it, n, cv, t, k, ek); end
            end
        end
    endtask

    initial begin
        repeat (2) step();
        test_reset();
        test_oneshot();
        test_reload();
        test_masked();
        test_stop_ignored();
        test_preset_during_cnt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq_source.md
Name: timer_irq_source

Overview:
Memory-mapped countdown timer that is the interrupt source feeding one bit of the CP0 HWInt[7:2] vector. Software programs it through the data-memory bus with sw/lw in the MEM stage. It raises a level interrupt request (irq) that CP0 samples into Cause.IP and masks with SR.IM. It supports one-shot (mode 0) and auto-reload (mode 1) operation.

Parameters:
PRESCALE_DIV, 4, clock cycles per count decrement; used only when TIMER_PRESCALE_EN is defined; legal values are 2 and up.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge of clk resets the block).
addr  input  2  word select, bus address [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
we  input  1  write strobe from the MEM-stage store decode.
wdata  input  32  store data.
rdata  output  32  combinational read data for the selected word.
irq  output  1  interrupt request to CP0 HWInt.

Behaviour:
- Registers:
  - CTRL is {28'b0, IM[3], MODE[2:1], EN[0]}. Writes keep only wdata[3:0].
  - PRESET is a 32-bit read/write register.
  - COUNT is 32-bit and read-only. Writes to addr 2 or 3 are ignored.
- Reads:
  - rdata = CTRL, PRESET, or COUNT by addr; addr 3 reads 0. Purely combinational.
  - MODE values 2 and 3 behave as mode 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0.
- FSM has four states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT frozen.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0), COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - Mode 0: EN<=0, go to IDLE; irq_flag stays 1.
    - Mode 1: irq_flag<=0, go to LOAD (one-cycle pulse).
- irq = irq_flag & IM. IM only gates the output; counting proceeds regardless.
- Latency, with the write edge of EN=1 counted as edge 0 and N=PRESET:
  - state is LOAD after edge 1;
  - irq rises after edge 2+max(N,1);
  - mode-1 period is max(N,1)+2 cycles.
- Clearing the sticky mode-0 irq_flag: any CTRL or PRESET write clears it at that edge.
- Simultaneous events:
  - A CTRL write at the same edge as the FSM's EN clear in INT: the software write wins.
  - A PRESET write during CNT: takes effect at the next LOAD only.
  - An EN=0 write in LOAD: LOAD completes, then CNT sees EN=0 and goes to IDLE.
- Reset mid-operation (any state, irq high or low): all registers return to reset values at that edge; irq=0 on the following cycle.
- COUNT never wraps below 0.

Optional Feature:
Macro TIMER_PRESCALE_EN.
- Defined: in CNT, COUNT decrements (or the INT transition fires) only when a prescale counter reaches PRESCALE_DIV-1. The prescale counter is cleared in LOAD and by reset. irq rises after edge 2+max(N,1)*PRESCALE_DIV.
- Not defined: COUNT steps every cycle, as described above, and PRESCALE_DIV is ignored.

Decomposition:
- Shared header define.v holds:
  - address word indices: TC_CTRL=0, TC_PRESET=1, TC_COUNT=2;
  - CTRL bit positions: EN=0, MODE=2:1, IM=3;
  - mode encodings: MODE_ONESHOT=0, MODE_RELOAD=1;
  - FSM state encodings (2 bits).
- Sub-module timer_prescaler (free-running modulo counter with a clear input and a tick output). It is instantiated only under TIMER_PRESCALE_EN; everything else stays in one module.

Test Plan:
1. Reset: hold reset=0 for one edge with arbitrary prior state -> rdata=0 at addr 0, 1 and 2; irq=0.
2. Mode 0: write PRESET=5, then CTRL=0x9 -> irq rises after edge 7; COUNT reads 0; CTRL reads 0x8; irq stays high. Then write CTRL=0x8 -> irq=0 after that edge.
3. Mode 1: PRESET=3, CTRL=0xB -> one-cycle irq pulses, the first after edge 5, then every 5 cycles; COUNT reads 3,2,1,0 cyclically.
4. Masked: PRESET=2, CTRL=0x3 -> irq never asserts; COUNT keeps reloading with period 4.
5. Stop and ignored write: PRESET=10, CTRL=0x9, then after 4 cycles write CTRL=0x0 and write 0x55 to addr 2 -> COUNT frozen at 8; irq=0.
6. Simultaneous events and mid-run reset:
   - A PRESET write during CNT -> the old count finishes; the new value loads on the next mode-1 LOAD.
   - A reset pulse while irq=1 -> all reads return 0 and irq=0 on the next cycle.
